// File: rtl/idft_wb_sequencer.sv
// idft_wb_sequencer: Wishbone master that loads one 8-sample complex frame
// into the IDFT accelerator, starts it, polls for done, reads the 8 results
// back and streams them out with index and last markers.
module idft_wb_sequencer #(
    parameter int unsigned DW          = 32,
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned POLL_MAX    = 1000
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_real,
    input  logic [DW-1:0] in_imag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_real,
    output logic [DW-1:0] out_imag,
    output logic [2:0]    out_idx,
    output logic          out_last,
    output logic          busy,
    output logic          err,
    output logic          CYC_O,
    output logic          STB_O,
    output logic          WE_O,
    output logic [7:0]    ADR_O,
    output logic [DW-1:0] DAT_O,
    input  logic [DW-1:0] DAT_I,
    input  logic          ACK_I
);

    localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int unsigned PW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;

    typedef enum logic [2:0] {IDLE, FILL, WRITE, START, POLL, READ, DRAIN} state_t;

    state_t          state, state_d;
    logic            cyc, we;
    logic [7:0]      adr;
    logic [DW-1:0]   dat_o;
    logic [TW-1:0]   tcnt;
    logic [PW-1:0]   pcnt;
    logic [3:0]      widx;
    logic [2:0]      fill_idx;
    logic            in_ready_q, err_q;
    logic            accept, ack_ev, abort, launch, drain_hs;
    logic [DW-1:0]   sbuf_re [8];
    logic [DW-1:0]   sbuf_im [8];

    assign CYC_O    = cyc;
    assign STB_O    = cyc;
    assign WE_O     = we;
    assign ADR_O    = adr;
    assign DAT_O    = dat_o;
    assign in_ready = in_ready_q;
    assign err      = err_q;
    assign busy     = !(state == IDLE || state == FILL);
    assign accept   = in_valid & in_ready_q;
    assign ack_ev   = cyc & ACK_I;
    assign drain_hs = out_valid & out_ready;

    // Next-state, abort detection and transaction launch decision
    always_comb begin
        state_d = state;
        abort   = 1'b0;
        launch  = 1'b0;
        case (state)
            IDLE, FILL: if (accept) state_d = (fill_idx == 3'd7) ? WRITE : FILL;
            WRITE:      if (ack_ev && widx == 4'd15) state_d = START;
            START:      if (ack_ev) state_d = POLL;
            POLL: begin
                if (ack_ev) begin
                    if (DAT_I[0]) state_d = READ;
                    else if (pcnt == PW'(POLL_MAX - 1)) abort = 1'b1;
                end
            end
            READ:       if (ack_ev && widx == 4'd15) state_d = DRAIN;
            DRAIN:      if (drain_hs && out_idx == 3'd7) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
        // An ACK on the timeout edge completes the transaction instead
        if (cyc && !ACK_I && tcnt == TW'(ACK_TIMEOUT - 1)) abort = 1'b1;
        // Bus idle for one cycle in a bus state: issue the next transaction
        if ((state == WRITE || state == START || state == POLL || state == READ) && !cyc)
            launch = 1'b1;
        if (abort) begin
            state_d = IDLE;
            launch  = 1'b0;
        end
    end

    // State register and input-side ready
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state      <= IDLE;
            in_ready_q <= 1'b0;
        end else begin
            state      <= state_d;
            in_ready_q <= (state_d == IDLE || state_d == FILL);
        end
    end

    // Frame buffer, counters, sticky error and registered Wishbone master outputs
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            cyc      <= 1'b0;
            we       <= 1'b0;
            adr      <= '0;
            dat_o    <= '0;
            tcnt     <= '0;
            pcnt     <= '0;
            widx     <= '0;
            fill_idx <= '0;
            err_q    <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                sbuf_re[i] <= '0;
                sbuf_im[i] <= '0;
            end
        end else begin
            if (accept) begin
                sbuf_re[fill_idx] <= in_real;
                sbuf_im[fill_idx] <= in_imag;
                fill_idx          <= fill_idx + 3'd1;
                if (fill_idx == 3'd0) err_q <= 1'b0;
            end
            if (abort) begin
                cyc      <= 1'b0;
                we       <= 1'b0;
                adr      <= '0;
                dat_o    <= '0;
                tcnt     <= '0;
                pcnt     <= '0;
                widx     <= '0;
                fill_idx <= '0;
                err_q    <= 1'b1;
            end else if (ack_ev) begin
                cyc   <= 1'b0;
                we    <= 1'b0;
                adr   <= '0;
                dat_o <= '0;
                tcnt  <= '0;
                if (state == WRITE) widx <= widx + 4'd1;
                if (state == READ) begin
                    widx <= widx + 4'd1;
                    if (widx[0]) sbuf_im[widx[3:1]] <= DAT_I;
                    else         sbuf_re[widx[3:1]] <= DAT_I;
                end
                if (state == POLL) pcnt <= DAT_I[0] ? '0 : pcnt + PW'(1);
            end else if (cyc) begin
                tcnt <= tcnt + TW'(1);
            end else if (launch) begin
                cyc  <= 1'b1;
                tcnt <= '0;
                case (state)
                    WRITE: begin
                        we    <= 1'b1;
                        adr   <= {(widx[0] ? 4'h2 : 4'h1), 1'b0, widx[3:1]};
                        dat_o <= widx[0] ? sbuf_im[widx[3:1]] : sbuf_re[widx[3:1]];
                    end
                    START: begin
                        we    <= 1'b1;
                        adr   <= 8'h00;
                        dat_o <= DW'(1);
                    end
                    POLL: begin
                        we    <= 1'b0;
                        adr   <= 8'h08;
                        dat_o <= '0;
                    end
                    READ: begin
                        we    <= 1'b0;
                        adr   <= {(widx[0] ? 4'h4 : 4'h3), 1'b0, widx[3:1]};
                        dat_o <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Result stream: load k=0 on entry to DRAIN, advance on each handshake
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            out_valid <= 1'b0;
            out_real  <= '0;
            out_imag  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else if (state == READ && state_d == DRAIN) begin
            out_valid <= 1'b1;
            out_real  <= sbuf_re[0];
            out_imag  <= sbuf_im[0];
            out_idx   <= 3'd0;
            out_last  <= 1'b0;
        end else if (state == DRAIN && drain_hs) begin
            if (out_idx == 3'd7) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                out_real  <= sbuf_re[out_idx + 3'd1];
                out_imag  <= sbuf_im[out_idx + 3'd1];
                out_idx   <= out_idx + 3'd1;
                out_last  <= (out_idx == 3'd6);
            end
        end
    end

endmodule
